// File: rtl/msg_scheduler_if.sv
// ---------------------------------------------------------------------------
// msg_scheduler_if
// Bundles the message-load handshake and the compressor-facing drive signals
// of the message scheduler.
//   start       : begin a block (sampled only while idle)
//   msg_word    : 32-bit message word, word 0 first
//   msg_valid   : msg_word valid
//   msg_ready   : scheduler can accept a word (LOAD only)
//   w           : schedule word for the compressor
//   cur_round   : round index aligned with w
//   comp_en     : compressor enable
//   comp_init   : compressor init (load hash state)
//   busy        : scheduler not idle
//   block_done  : one-cycle pulse after a block has fully drained
// Modports: slave = scheduler side, master = source/compressor side.
// ---------------------------------------------------------------------------
interface msg_scheduler_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  start;
  logic [WORD_WIDTH-1:0] msg_word;
  logic                  msg_valid;
  logic                  msg_ready;
  logic [WORD_WIDTH-1:0] w;
  logic [5:0]            cur_round;
  logic                  comp_en;
  logic                  comp_init;
  logic                  busy;
  logic                  block_done;

  modport slave (
    input  start, msg_word, msg_valid,
    output msg_ready, w, cur_round, comp_en, comp_init, busy, block_done
  );

  modport master (
    output start, msg_word, msg_valid,
    input  msg_ready, w, cur_round, comp_en, comp_init, busy, block_done
  );
endinterface

// File: rtl/msg_scheduler.sv
// ---------------------------------------------------------------------------
// msg_scheduler
// Message-schedule stage feeding the round compressor. Loads one 512-bit
// block as 16 words over a valid/ready handshake, then emits W0..W63 from a
// 16-word sliding window, cycle-aligned with cur_round/comp_en/comp_init.
// Ports:
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset (aborts any block in flight)
//   bus   : msg_scheduler_if.slave (handshake + compressor drive signals)
// Sequence: IDLE -> LOAD (16 accepts) -> INIT (W0) -> RUN (W1..W63)
//           -> FLUSH (compressor finishes round 63) -> IDLE (+block_done).
// ---------------------------------------------------------------------------
module msg_scheduler #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  msg_scheduler_if.slave    bus
);

  if (WORD_WIDTH != 32) begin : g_bad_width
    $error("msg_scheduler: only WORD_WIDTH=32 is supported");
  end
  if (NUM_ROUNDS != 64) begin : g_bad_rounds
    $error("msg_scheduler: only NUM_ROUNDS=64 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_load_cnt;
  logic [5:0]        r_round;
  logic [15:0][31:0] r_win;      // r_win[0] = W_t ... r_win[15] = W_t+15
  logic              r_done;

  logic              w_accept;
  logic              w_expanding;
  logic [31:0]       w_expand;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // msg_ready is a pure state decode, so accept never loops back into ready.
  assign w_accept    = (r_state == S_LOAD) && bus.msg_valid;
  assign w_expanding = (r_state == S_INIT) || (r_state == S_RUN);

  // Next word appended at the top of the window: W_t+16.
  assign w_expand = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && (r_load_cnt == 4'd15)) w_state_nxt = S_INIT;
      S_INIT:  w_state_nxt = S_RUN;
      S_RUN:   if (r_round == 6'd63) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_load_cnt <= 4'd0;
      r_round    <= 6'd0;
      r_win      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // FLUSH always leaves to IDLE, so this marks the first IDLE cycle.
      r_done  <= (r_state == S_FLUSH);

      // 4-bit count wraps to 0 on the 16th accept, ready for the next block.
      if (w_accept) r_load_cnt <= r_load_cnt + 4'd1;

      if (w_accept)
        r_win <= {bus.msg_word, r_win[15:1]};
      else if (w_expanding)
        r_win <= {w_expand, r_win[15:1]};

      // Round index for RUN: INIT primes 1, RUN steps to 63 and wraps to 0
      // on the way into FLUSH.
      if (r_state == S_INIT)
        r_round <= 6'd1;
      else if (r_state == S_RUN)
        r_round <= r_round + 6'd1;
      else
        r_round <= 6'd0;
    end
  end

  // Outputs are decodes of registered state only.
  assign bus.msg_ready  = (r_state == S_LOAD);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.comp_en    = w_expanding || (r_state == S_FLUSH);
  assign bus.comp_init  = (r_state == S_INIT);
  assign bus.w          = w_expanding ? r_win[0] : 32'd0;
  assign bus.cur_round  = (r_state == S_RUN) ? r_round : 6'd0;
  assign bus.block_done = r_done;

endmodule

// File: tb/tb_msg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_msg_scheduler
// Directed sequence of blocks (fixed and random words, several valid
// patterns, start held/pulsed, reset mid-run) checked cycle by cycle
// against a schedule model computed from the message-expansion rules.
// ---------------------------------------------------------------------------
module tb_msg_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  msg_scheduler_if bus ();

  msg_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] mw    [16];
  logic [31:0] ref_w [64];
  logic [31:0] obs_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block schedule: W0..W15 are the message, Wt computed by recurrence.
  function automatic void build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = mw[t];
      else ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                    + ref_w[t-7]
                    + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                    + ref_w[t-16];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [31:0] wv,
                         input logic [5:0] rnd, input logic en, input logic init,
                         input logic bsy, input logic done);
    chk({tag, ".msg_ready"},  {31'd0, bus.msg_ready},  {31'd0, rdy});
    chk({tag, ".w"},          bus.w,                   wv);
    chk({tag, ".cur_round"},  {26'd0, bus.cur_round},  {26'd0, rnd});
    chk({tag, ".comp_en"},    {31'd0, bus.comp_en},    {31'd0, en});
    chk({tag, ".comp_init"},  {31'd0, bus.comp_init},  {31'd0, init});
    chk({tag, ".busy"},       {31'd0, bus.busy},       {31'd0, bsy});
    chk({tag, ".block_done"}, {31'd0, bus.block_done}, {31'd0, done});
  endtask

  // Runs one block from a negedge in IDLE (or in the block_done cycle).
  // vmode: 0 valid held, 1 toggling 1,0,1..., 2 random.
  // chained: start was already high in the previous block_done cycle.
  // noise: random start activity while busy. abort: round at which rst hits (0 = none).
  task automatic run_block(input int vmode, input bit hold, input bit chained,
                           input bit noise, input int abort, input logic end_start);
    int k;
    int guard;
    logic v;
    build_ref();
    if (!chained) bus.start = 1'b1;
    @(negedge clk);
    bus.start = hold;
    k = 0;
    guard = 0;
    while (k < 16 && guard < 200) begin
      chk("load", {31'd0, bus.msg_ready}, 32'd1);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.msg_valid = v;
      bus.msg_word  = v ? mw[k] : $urandom;
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (v) k++;
      guard++;
    end
    if (k < 16) chk("load_timeout", k, 32'd16);
    bus.msg_valid = 1'b0;
    chk_all("init", 1'b0, ref_w[0], 6'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    obs_w[0] = bus.w;
    for (int r = 1; r < 64; r++) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all("run", 1'b0, ref_w[r], 6'(r), 1'b1, 1'b0, 1'b1, 1'b0);
      obs_w[r] = bus.w;
      if (r == abort) begin
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk_all("abort", 1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        return;
      end
    end
    if (noise) bus.start = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_all("flush", 1'b0, 32'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (noise) bus.start = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_all("done", 1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.start = end_start;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) mw[i] = 32'd0;
    mw[0]  = 32'h61626380;
    mw[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) mw[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_word  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("idle", 1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // "abc" block, valid held high
    set_abc();
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("abc.W16", obs_w[16], 32'h61626380);
    chk("abc.W17", obs_w[17], 32'h000F0000);

    // reset in the middle of RUN, then a clean reload
    set_rand();
    run_block(2, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    @(negedge clk);
    chk("post_abort.busy", {31'd0, bus.busy}, 32'd0);
    set_rand();
    run_block(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // "abc" block with toggling valid
    set_abc();
    run_block(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("abc_toggle.W17", obs_w[17], 32'h000F0000);

    // all-ones words
    for (int i = 0; i < 16; i++) mw[i] = 32'hFFFFFFFF;
    run_block(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("ones.W16", obs_w[16], 32'h203FFFFC);

    // start held high across two back-to-back blocks
    set_rand();
    run_block(2, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    set_rand();
    run_block(0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("after_chain.busy", {31'd0, bus.busy}, 32'd0);

    // start noise while busy must be ignored
    for (int b = 0; b < 3; b++) begin
      set_rand();
      run_block(2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      @(negedge clk);
      chk("after_noise.busy", {31'd0, bus.busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
